// File: rtl/pc_redirect_if.sv
// PC redirect request/response bundle between the pipeline and pc_redirect_ctrl.
// master drives redirect requests; slave is the controller producing the PC select.
interface pc_redirect_if;
    logic [2:0]  ex_entry_sel;
    logic [31:0] entry_pc;
    logic        br_taken;
    logic        br_is_jr;
    logic [31:0] br_target;
    logic        j_valid;
    logic [31:0] j_target;
    logic        fetch_ready;
    logic [2:0]  pc_sel;
    logic [31:0] pc_target;
    logic        pc_we;
    logic        flush_req;
    logic        redirect_pending;
    logic [31:0] redirect_cnt;
    logic [31:0] hold_cnt;

    modport master (
        output ex_entry_sel, entry_pc, br_taken, br_is_jr, br_target,
               j_valid, j_target, fetch_ready,
        input  pc_sel, pc_target, pc_we, flush_req, redirect_pending,
               redirect_cnt, hold_cnt
    );

    modport slave (
        input  ex_entry_sel, entry_pc, br_taken, br_is_jr, br_target,
               j_valid, j_target, fetch_ready,
        output pc_sel, pc_target, pc_we, flush_req, redirect_pending,
               redirect_cnt, hold_cnt
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC source arbiter: prioritises exception/jump/branch redirects and holds them while fetch stalls.
// Optional REDIRECT_STAT_EN adds redirect and hold-cycle counters.
module pc_redirect_ctrl (
    input  logic             clk,
    input  logic             rst,
    pc_redirect_if.slave     bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned SELW = 3;

    localparam logic [SELW-1:0] SEL_PC4    = 3'b000;
    localparam logic [SELW-1:0] SEL_IMMJ   = 3'b001;
    localparam logic [SELW-1:0] SEL_EPC    = 3'b010;
    localparam logic [SELW-1:0] SEL_EXCEPT = 3'b011;
    localparam logic [SELW-1:0] SEL_BRANCH = 3'b100;
    localparam logic [SELW-1:0] SEL_JR     = 3'b101;
    localparam logic [SELW-1:0] SEL_MEMPC  = 3'b110;
    localparam logic [SELW-1:0] SEL_REFILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SELW-1:0]   held_sel_q, held_sel_d;
    logic [XLEN-1:0]   held_target_q, held_target_d;

    logic              ex_hit_c;
    logic [SELW-1:0]   ex_sel_c;
    logic [SELW-1:0]   cand_sel_c;
    logic [XLEN-1:0]   cand_target_c;
    logic              held_is_ex_c;
    logic [SELW-1:0]   pc_sel_c;
    logic [XLEN-1:0]   pc_target_c;
    logic              pc_we_c;
    logic              flush_c;
    logic              pending_c;

    function automatic logic sel_is_ex(input logic [SELW-1:0] s);
        return (s == SEL_EPC) || (s == SEL_EXCEPT) || (s == SEL_MEMPC) || (s == SEL_REFILL);
    endfunction

    // Exception-class decode; unlisted encodings behave as no request.
    always_comb begin
        ex_hit_c = 1'b1;
        ex_sel_c = SEL_PC4;
        case (bus.ex_entry_sel)
            3'b001:  ex_sel_c = SEL_EPC;
            3'b010:  ex_sel_c = SEL_EXCEPT;
            3'b011:  ex_sel_c = SEL_MEMPC;
            3'b100:  ex_sel_c = SEL_REFILL;
            default: ex_hit_c = 1'b0;
        endcase
    end

    // Candidate source for IDLE/SQUASH; SQUASH only honours exception-class requests.
    always_comb begin
        cand_sel_c    = SEL_PC4;
        cand_target_c = '0;
        if (ex_hit_c) begin
            cand_sel_c    = ex_sel_c;
            cand_target_c = bus.entry_pc;
        end else if (state_q != SQUASH) begin
            if (bus.j_valid) begin
                cand_sel_c    = SEL_IMMJ;
                cand_target_c = bus.j_target;
            end else if (bus.br_taken) begin
                cand_sel_c    = bus.br_is_jr ? SEL_JR : SEL_BRANCH;
                cand_target_c = bus.br_target;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        held_sel_d    = held_sel_q;
        held_target_d = held_target_q;
        pc_sel_c      = SEL_PC4;
        pc_target_c   = '0;
        pc_we_c       = 1'b0;
        pending_c     = 1'b0;
        held_is_ex_c  = sel_is_ex(held_sel_q);

        case (state_q)
            HOLD: begin
                pc_sel_c    = held_sel_q;
                pc_target_c = held_target_q;
                pc_we_c     = bus.fetch_ready;
                pending_c   = 1'b1;
                // A late exception replaces a held branch/jump and keeps us in HOLD.
                if (ex_hit_c && !held_is_ex_c) begin
                    held_sel_d    = ex_sel_c;
                    held_target_d = bus.entry_pc;
                end else if (bus.fetch_ready) begin
                    state_d = held_is_ex_c ? SQUASH : IDLE;
                end
            end
            default: begin
                pc_sel_c    = cand_sel_c;
                pc_target_c = cand_target_c;
                if (bus.fetch_ready) begin
                    pc_we_c = 1'b1;
                    state_d = ex_hit_c ? SQUASH : IDLE;
                end else if (cand_sel_c != SEL_PC4) begin
                    held_sel_d    = cand_sel_c;
                    held_target_d = cand_target_c;
                    state_d       = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        flush_c = pc_we_c && sel_is_ex(pc_sel_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            held_sel_q    <= SEL_PC4;
            held_target_q <= '0;
        end else begin
            state_q       <= state_d;
            held_sel_q    <= held_sel_d;
            held_target_q <= held_target_d;
        end
    end

    // Reset must clear the zero-latency outputs immediately, not at the next edge.
    assign bus.pc_sel           = rst ? SEL_PC4 : pc_sel_c;
    assign bus.pc_target        = rst ? '0 : pc_target_c;
    assign bus.pc_we            = !rst && pc_we_c;
    assign bus.flush_req        = !rst && flush_c;
    assign bus.redirect_pending = !rst && pending_c;

`ifdef REDIRECT_STAT_EN
    logic [XLEN-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [XLEN-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q + XLEN'(pc_we_c && (pc_sel_c != SEL_PC4));
        hold_cnt_d     = hold_cnt_q + XLEN'((state_q == HOLD) && !bus.fetch_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            hold_cnt_q     <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.hold_cnt     = hold_cnt_q;
`else
    assign bus.redirect_cnt = '0;
    assign bus.hold_cnt     = '0;
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: ex_entry_sel  in  3  exception-class request (000 None, 001 Eret, 010 Exception, 011 Refetch, 100 Refill; others illegal, treated as None).
REQ-004 SHALL have: entry_pc  in  32  target for any non-None ex_entry_sel.
REQ-005 SHALL have: br_taken  in  1  EX branch/JR resolved taken; br_is_jr  in  1  taken branch is JR; br_target  in  32.
REQ-006 SHALL have: j_valid  in  1  ID immediate jump; j_target  in  32.
REQ-007 SHALL have: fetch_ready  in  1  PC register may update this cycle.
REQ-008 SHALL have outputs: pc_sel  out  3 (000 PC4, 001 ImmeJump, 010 EPC, 011 Except, 100 Branch, 101 JR, 110 MEMPC, 111 Refill); pc_target  out  32; pc_we  out  1; flush_req  out  1; redirect_pending  out  1.
REQ-009 SHALL have: redirect_cnt  out  32; hold_cnt  out  32.

Function
REQ-010 Priority SHALL be exception-class > j_valid > br_taken (JR if br_is_jr else Branch) > PC4; mapping Eret->010, Exception->011, Refetch->110, Refill->111.
REQ-011 pc_target SHALL be entry_pc, j_target or br_target per selected source; 32'h0 for PC4.
REQ-012 States SHALL be IDLE, HOLD, SQUASH.
REQ-013 IDLE, fetch_ready=1: pc_sel/pc_target from REQ-010, pc_we=1, zero latency; exception-class winner -> SQUASH, else stay IDLE.
REQ-014 IDLE, fetch_ready=0, winner not PC4: latch held_sel/held_target, pc_we=0 -> HOLD; winner PC4: pc_we=0, stay IDLE.
REQ-015 HOLD: pc_sel/pc_target from held registers; redirect_pending=1; pc_we=fetch_ready.
REQ-016 HOLD, new exception-class request, held is branch/jump: SHALL overwrite held registers the same edge; held exception-class SHALL never be overwritten; branch/jump inputs SHALL be ignored in HOLD.
REQ-017 HOLD, fetch_ready=1: commit held redirect; -> SQUASH if held exception-class, else IDLE; simultaneous exception-class arrival is latched per REQ-016 and becomes the committed value next cycle (stay HOLD).
REQ-018 SQUASH (exactly one cycle): j_valid/br_taken ignored; exception-class requests handled as in IDLE; otherwise pc_sel=PC4, pc_we=fetch_ready; -> IDLE unless REQ-013/014 dictates otherwise.
REQ-019 flush_req SHALL be 1 exactly in the cycle an exception-class redirect is committed (pc_we=1, pc_sel in {010,011,110,111}).
REQ-020 Illegal ex_entry_sel SHALL not alter state and SHALL be treated as None.

Reset
REQ-021 rst=1 SHALL force state IDLE, held_sel=000, held_target=0, pc_we=0, flush_req=0, redirect_pending=0, pc_sel=000, pc_target=0, counters 0, asynchronously.
REQ-022 rst asserted while in HOLD SHALL discard the held redirect; first cycle after deassert behaves as IDLE.

Configuration
REQ-023 Macro REDIRECT_STAT_EN: when defined, redirect_cnt SHALL increment per committed non-PC4 redirect and hold_cnt per cycle in HOLD with fetch_ready=0, both wrapping 32'hFFFFFFFF->0.
REQ-024 Without REDIRECT_STAT_EN, redirect_cnt and hold_cnt SHALL be tied to 0, no counter flops; all other behaviour identical.

Verification
REQ-025 IDLE, fetch_ready=1, br_taken=1, br_is_jr=0, br_target=32'h80001000 -> same cycle pc_sel=100, pc_target=32'h80001000, pc_we=1, flush_req=0.
REQ-026 fetch_ready=0, j_valid=1, j_target=32'hBFC00400 for 3 cycles, then fetch_ready=1 -> redirect_pending=1 for 3 cycles, 4th cycle pc_sel=001, pc_we=1, then IDLE.
REQ-027 HOLD with Branch held, ex_entry_sel=010, entry_pc=32'hBFC00380 -> next cycle held_sel=011; on fetch_ready=1 pc_sel=011, flush_req=1, next cycle SQUASH ignores br_taken=1 (pc_sel=000).
REQ-028 ex_entry_sel=001 and j_valid=1 same cycle, fetch_ready=1 -> pc_sel=010, pc_target=entry_pc, flush_req=1.
REQ-029 rst pulsed mid-HOLD -> all outputs 0 immediately; after release with fetch_ready=1, no inputs -> pc_sel=000, pc_we=1.
REQ-030 With REDIRECT_STAT_EN, redirect_cnt preloaded via forced state at 32'hFFFFFFFF, one committed branch -> redirect_cnt=0; without macro both counters read 0.
